mem_dut_axi_rd_resp_chk_256: RTL and testbench
==============================================

# mem_dut_axi_rd_resp_chk_256

Read-response checker for the 256-bit memory-DUT pattern generator. Sits downstream of the AXI request generator on the R channel: accepts read beats, compares them against the generator's golden data/strobe and expected AR info (ID, length, size), and reports errors. It drives the generator's `arcmd_info_update` and `axi_rdata_cnt_total` inputs, which advance the golden stream.

## Interface
- `DATA_W`, 256, R data width; fixed, other values unsupported.
- `BYTE_W`, 32, `DATA_W/8`; compare lanes.
- `pg_clk` in 1: clock.
- `pg_rstn` in 1: reset. Synchronous, active-low; one clock.
- `status_clear` in 1: clear counters, errors and FSM; same pulse the generator sees.
- `stop_on_err` in 1: halt R acceptance after first error.
- `rready_mode` in 2: 0 always ready, 1 ready every other cycle, 2 ready 1 of 4, 3 never.
- `pg_axi_arcmd_info` in 27: expected {size[26:24], burst[23:22], len[21:14], id[13:0]}.
- `pg_axi_rdata` in 256: golden data for current `axi_rdata_cnt_total`.
- `pg_axi_rstrb` in 64: golden byte mask; bits [31:0] used.
- `axi_rvalid` in 1, `axi_rid` in 14, `axi_rdata` in 256, `axi_rresp` in 2, `axi_rlast` in 1: AXI R channel.
- `axi_rready` out 1: R ready.
- `arcmd_info_update` out 1: pulse, burst completed.
- `axi_rdata_cnt_total` out 32: beats accepted since clear.
- `rd_burst_cnt` out 32: bursts completed.
- `err_data_cnt` out 16: beats with data mismatch; saturates at 0xFFFF.
- `err_flags` out 4: sticky {resp, last, id, data}.
- `first_err_beat` out 32: `axi_rdata_cnt_total` value of first failing beat.
- `chk_halted` out 1: FSM in HALT.

## Operation
- FSM: IDLE (no burst open), BURST (beat_idx>0), HALT.
- Handshake `hs = axi_rvalid & axi_rready`. `axi_rready` = 0 in HALT, during `status_clear`, or when `rready_mode`=3; otherwise a pattern gated by a 2-bit free-running phase counter (reset 0).
- Per accepted beat, all evaluated against current inputs:
  - id error: `axi_rid != info.id`.
  - resp error: `axi_rresp != 2'b00`.
  - last error: `axi_rlast != (beat_idx == info.len)`.
  - data error: any byte i with `cmp_mask[i]` and `axi_rdata` byte i != `pg_axi_rdata` byte i.
  - `cmp_mask = pg_axi_rstrb[31:0] & (((1<<(1<<size))-1) << ((beat_idx<<size)%32))`, with size clamped to 5.
- Burst end is expected-length based: `hs && beat_idx == info.len`. It pulses `arcmd_info_update`, increments `rd_burst_cnt` and returns to IDLE, regardless of `axi_rlast`. Otherwise `beat_idx++` and go to BURST.
- Any error sets its sticky flag. The first error (all flags 0) latches `first_err_beat`. If `stop_on_err`, go to HALT after the beat.
- HALT exits only on `status_clear` or reset.
- `status_clear` takes priority over `hs` in the same cycle:
  - all counters, flags and beat_idx go to 0; FSM goes to IDLE;
  - no update pulse.

## Timing
- Reset/clear values:
  - `axi_rready`=0 in the reset cycle; it follows `rready_mode` from the next cycle.
  - All counters, flags, `first_err_beat`, `chk_halted` and `arcmd_info_update` are 0.
- `arcmd_info_update` is combinational (`hs` and end condition), so the generator's arid advances at the same edge. A following burst's first beat on the next cycle sees the updated info.
- `axi_rdata_cnt_total`, counters and flags are registered; they update at the edge after `hs`. Golden data follows one cycle later, which supports back-to-back beats.
- Check latency: errors are visible the cycle after the failing beat.
- `len`=0: single-beat burst ends on its first beat.
- `beat_idx` is 8 bits and never wraps, because it is bounded by `len` ≤ 255.
- Counters wrap at 2^32, except `err_data_cnt`, which saturates.

## Structure
- Shared package `mem_dut_axi_pkg`:
  - arcmd info field offsets;
  - `RRESP_OKAY`;
  - FSM state enum;
  - `rready_mode` encodings.
- One sub-module, `mem_dut_rdata_cmp_256`: combinational lane mask plus byte-wise compare, outputs a 1-bit mismatch.
- Top holds the FSM, counters and error capture.

## Test plan
- Info len=3, size=5, id=0x005, rstrb all-ones, 4 matching beats with rlast on beat 3 -> one `arcmd_info_update` pulse on beat 3; `axi_rdata_cnt_total`=4, `rd_burst_cnt`=1, `err_flags`=0.
- Beat 2 of a 4-beat burst with byte 7 corrupted -> `err_flags`=4'b0001, `err_data_cnt`=1, `first_err_beat`=2. Repeat with byte 7 masked off in rstrb -> no error.
- `axi_rid`=0x006 vs expected 0x005 with `stop_on_err`=1 -> id flag set, HALT, `axi_rready`=0 until `status_clear`, then all zero.
- rlast asserted on beat 1 of len=3 -> last flag set; burst still ends at beat 3 (one update pulse).
- `rready_mode`=1 with continuous rvalid -> `axi_rready` alternates; 8 beats take 16 cycles; size=3 narrow beats compare lanes 0-7, 8-15, … per beat.
- `status_clear` coincident with the last-beat handshake -> no update pulse, counters 0, FSM IDLE.

Source files
------------

// File: rtl/mem_dut_axi_pkg.sv
// Shared definitions for the 256-bit memory-DUT AXI read path:
// arcmd info field offsets, response encoding, checker FSM states and
// rready pacing modes.
package mem_dut_axi_pkg;

  // pg_axi_arcmd_info = {size[26:24], burst[23:22], len[21:14], id[13:0]}
  localparam int unsigned ARINFO_ID_LSB    = 0;
  localparam int unsigned ARINFO_ID_W      = 14;
  localparam int unsigned ARINFO_LEN_LSB   = 14;
  localparam int unsigned ARINFO_LEN_W     = 8;
  localparam int unsigned ARINFO_BURST_LSB = 22;
  localparam int unsigned ARINFO_BURST_W   = 2;
  localparam int unsigned ARINFO_SIZE_LSB  = 24;
  localparam int unsigned ARINFO_SIZE_W    = 3;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  // Largest AxSIZE that fits a 256-bit beat (32 bytes).
  localparam logic [2:0] AXI_SIZE_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HALT  = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    RDY_ALWAYS  = 2'd0,
    RDY_HALF    = 2'd1,
    RDY_QUARTER = 2'd2,
    RDY_NEVER   = 2'd3
  } rready_mode_e;

endpackage

// File: rtl/mem_dut_rdata_cmp_256.sv
// Byte-lane compare of one R beat against golden data.
//   rdata_i    : received beat data
//   golden_i   : expected beat data
//   strb_i     : golden byte mask (one bit per lane)
//   size_i     : AxSIZE of the burst (clamped to 5)
//   beat_idx_i : beat index within the burst, selects the narrow lane window
//   mismatch_o : some enabled lane differs
module mem_dut_rdata_cmp_256
  import mem_dut_axi_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned BYTE_W = DATA_W / 8
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] golden_i,
  input  logic [BYTE_W-1:0] strb_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        beat_idx_i,
  output logic              mismatch_o
);

  logic [2:0]        size_c;
  logic [5:0]        nbytes;
  logic [63:0]       base_mask;
  logic [12:0]       lane_off;
  logic [BYTE_W-1:0] lane_mask;
  logic [BYTE_W-1:0] cmp_mask;

  // Narrow beats walk through the 32 lanes: window of 2^size bytes starting
  // at (beat_idx << size) mod 32. Base mask built wide so size=5 gives 32 ones.
  always_comb begin
    size_c    = (size_i > AXI_SIZE_MAX) ? AXI_SIZE_MAX : size_i;
    nbytes    = 6'd1 << size_c;
    base_mask = (64'd1 << nbytes) - 64'd1;
    lane_off  = {5'd0, beat_idx_i} << size_c;
    lane_mask = base_mask[BYTE_W-1:0] << lane_off[4:0];
    cmp_mask  = strb_i & lane_mask;
  end

  always_comb begin
    mismatch_o = 1'b0;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      if (cmp_mask[i] && (rdata_i[i*8 +: 8] != golden_i[i*8 +: 8])) begin
        mismatch_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_dut_axi_rd_resp_chk_256.sv
// AXI R-channel checker for the 256-bit memory-DUT pattern generator.
// Accepts read beats, checks id/resp/last/data against the generator's
// expected AR info and golden stream, and advances that stream.
//   pg_clk, pg_rstn       : clock, synchronous active-low reset
//   status_clear          : clear counters, flags and FSM
//   stop_on_err           : stop accepting beats after the first error
//   rready_mode           : rready pacing (always / 1-of-2 / 1-of-4 / never)
//   pg_axi_arcmd_info     : expected {size, burst, len, id}
//   pg_axi_rdata/rstrb    : golden data and byte mask for the current beat
//   axi_r*                : AXI R channel
//   arcmd_info_update     : burst completed (combinational pulse)
//   axi_rdata_cnt_total   : beats accepted since clear
//   rd_burst_cnt          : bursts completed
//   err_data_cnt          : data-mismatch beats (saturating)
//   err_flags             : sticky {resp, last, id, data}
//   first_err_beat        : beat count of the first failing beat
//   chk_halted            : checker halted on error
module mem_dut_axi_rd_resp_chk_256
  import mem_dut_axi_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned BYTE_W = DATA_W / 8
) (
  input  logic                pg_clk,
  input  logic                pg_rstn,
  input  logic                status_clear,
  input  logic                stop_on_err,
  input  logic [1:0]          rready_mode,
  input  logic [26:0]         pg_axi_arcmd_info,
  input  logic [DATA_W-1:0]   pg_axi_rdata,
  input  logic [2*BYTE_W-1:0] pg_axi_rstrb,
  input  logic                axi_rvalid,
  input  logic [13:0]         axi_rid,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  output logic                axi_rready,
  output logic                arcmd_info_update,
  output logic [31:0]         axi_rdata_cnt_total,
  output logic [31:0]         rd_burst_cnt,
  output logic [15:0]         err_data_cnt,
  output logic [3:0]          err_flags,
  output logic [31:0]         first_err_beat,
  output logic                chk_halted
);

  chk_state_e  state_q, state_d;
  logic [1:0]  phase_q;
  logic [7:0]  beat_idx_q, beat_idx_d;
  logic [31:0] total_q, total_d;
  logic [31:0] burst_q, burst_d;
  logic [15:0] err_data_q, err_data_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] first_q, first_d;

  logic [13:0] exp_id;
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;
  logic        pace_ok;
  logic        hs;
  logic        burst_end;
  logic        data_err;
  logic [3:0]  beat_errs;
  logic        unused_inputs;

  assign exp_id   = pg_axi_arcmd_info[ARINFO_ID_LSB   +: ARINFO_ID_W];
  assign exp_len  = pg_axi_arcmd_info[ARINFO_LEN_LSB  +: ARINFO_LEN_W];
  assign exp_size = pg_axi_arcmd_info[ARINFO_SIZE_LSB +: ARINFO_SIZE_W];

  assign unused_inputs = ^{pg_axi_rstrb[2*BYTE_W-1:BYTE_W],
                           pg_axi_arcmd_info[ARINFO_BURST_LSB +: ARINFO_BURST_W]};

  mem_dut_rdata_cmp_256 #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_cmp (
    .rdata_i    (axi_rdata),
    .golden_i   (pg_axi_rdata),
    .strb_i     (pg_axi_rstrb[BYTE_W-1:0]),
    .size_i     (exp_size),
    .beat_idx_i (beat_idx_q),
    .mismatch_o (data_err)
  );

  always_comb begin
    pace_ok = 1'b0;
    case (rready_mode_e'(rready_mode))
      RDY_ALWAYS:  pace_ok = 1'b1;
      RDY_HALF:    pace_ok = ~phase_q[0];
      RDY_QUARTER: pace_ok = (phase_q == 2'd0);
      RDY_NEVER:   pace_ok = 1'b0;
      default:     pace_ok = 1'b0;
    endcase
  end

  // Ready is gated by reset and clear combinationally, so a clear can never
  // coincide with a handshake and the update pulse needs no extra gating.
  assign axi_rready        = pg_rstn & ~status_clear & (state_q != ST_HALT) & pace_ok;
  assign hs                = axi_rvalid & axi_rready;
  assign burst_end         = hs & (beat_idx_q == exp_len);
  assign arcmd_info_update = burst_end;

  assign beat_errs = {(axi_rresp != RRESP_OKAY),
                      (axi_rlast != (beat_idx_q == exp_len)),
                      (axi_rid != exp_id),
                      data_err};

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    total_d    = total_q;
    burst_d    = burst_q;
    err_data_d = err_data_q;
    flags_d    = flags_q;
    first_d    = first_q;

    if (status_clear) begin
      state_d    = ST_IDLE;
      beat_idx_d = '0;
      total_d    = '0;
      burst_d    = '0;
      err_data_d = '0;
      flags_d    = '0;
      first_d    = '0;
    end else if (hs) begin
      total_d = total_q + 32'd1;
      if (data_err && (err_data_q != '1)) begin
        err_data_d = err_data_q + 16'd1;
      end
      flags_d = flags_q | beat_errs;
      if ((beat_errs != '0) && (flags_q == '0)) begin
        first_d = total_q;
      end
      if (burst_end) begin
        beat_idx_d = '0;
        burst_d    = burst_q + 32'd1;
        state_d    = ST_IDLE;
      end else begin
        beat_idx_d = beat_idx_q + 8'd1;
        state_d    = ST_BURST;
      end
      if ((beat_errs != '0) && stop_on_err) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge pg_clk) begin
    if (!pg_rstn) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      beat_idx_q <= '0;
      total_q    <= '0;
      burst_q    <= '0;
      err_data_q <= '0;
      flags_q    <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_q + 2'd1;
      beat_idx_q <= beat_idx_d;
      total_q    <= total_d;
      burst_q    <= burst_d;
      err_data_q <= err_data_d;
      flags_q    <= flags_d;
      first_q    <= first_d;
    end
  end

  assign axi_rdata_cnt_total = total_q;
  assign rd_burst_cnt        = burst_q;
  assign err_data_cnt        = err_data_q;
  assign err_flags           = flags_q;
  assign first_err_beat      = first_q;
  assign chk_halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_mem_dut_axi_rd_resp_chk_256.sv
module tb_mem_dut_axi_rd_resp_chk_256;

  logic         pg_clk = 1'b0;
  logic         pg_rstn = 1'b0;
  logic         status_clear = 1'b0;
  logic         stop_on_err = 1'b0;
  logic [1:0]   rready_mode = 2'd0;
  logic [26:0]  pg_axi_arcmd_info = '0;
  logic [255:0] pg_axi_rdata = '0;
  logic [63:0]  pg_axi_rstrb = '1;
  logic         axi_rvalid = 1'b0;
  logic [13:0]  axi_rid = '0;
  logic [255:0] axi_rdata = '0;
  logic [1:0]   axi_rresp = '0;
  logic         axi_rlast = 1'b0;
  logic         axi_rready;
  logic         arcmd_info_update;
  logic [31:0]  axi_rdata_cnt_total;
  logic [31:0]  rd_burst_cnt;
  logic [15:0]  err_data_cnt;
  logic [3:0]   err_flags;
  logic [31:0]  first_err_beat;
  logic         chk_halted;

  int errors = 0;
  int checks = 0;
  int unsigned upd_total = 0;
  logic [31:0] upd_at = '0;
  int unsigned cyc_hi = 0;

  mem_dut_axi_rd_resp_chk_256 #(.DATA_W(256), .BYTE_W(32)) dut (
    .pg_clk              (pg_clk),
    .pg_rstn             (pg_rstn),
    .status_clear        (status_clear),
    .stop_on_err         (stop_on_err),
    .rready_mode         (rready_mode),
    .pg_axi_arcmd_info   (pg_axi_arcmd_info),
    .pg_axi_rdata        (pg_axi_rdata),
    .pg_axi_rstrb        (pg_axi_rstrb),
    .axi_rvalid          (axi_rvalid),
    .axi_rid             (axi_rid),
    .axi_rdata           (axi_rdata),
    .axi_rresp           (axi_rresp),
    .axi_rlast           (axi_rlast),
    .axi_rready          (axi_rready),
    .arcmd_info_update   (arcmd_info_update),
    .axi_rdata_cnt_total (axi_rdata_cnt_total),
    .rd_burst_cnt        (rd_burst_cnt),
    .err_data_cnt        (err_data_cnt),
    .err_flags           (err_flags),
    .first_err_beat      (first_err_beat),
    .chk_halted          (chk_halted)
  );

  always #5 pg_clk = ~pg_clk;

  // Model of the free-running pacing phase: counts edges with reset released.
  always @(posedge pg_clk) if (pg_rstn) cyc_hi <= cyc_hi + 1;

  always @(negedge pg_clk) begin
    if (arcmd_info_update === 1'b1) begin
      upd_total = upd_total + 1;
      upd_at    = axi_rdata_cnt_total;
    end
  end

  function automatic logic [255:0] pat(int unsigned k);
    logic [255:0] p;
    for (int unsigned i = 0; i < 32; i++) p[i*8 +: 8] = 8'(k * 37 + i * 11 + 3);
    return p;
  endfunction

  function automatic logic [26:0] mk_info(logic [2:0] sz, logic [7:0] len, logic [13:0] id);
    return {sz, 2'b01, len, id};
  endfunction

  // Narrow (size=3) beat: correct only in its 8-byte window, all other lanes inverted.
  function automatic logic [255:0] mk_narrow(int unsigned b);
    logic [255:0] g;
    logic [255:0] d;
    int unsigned lo;
    g  = pat(b);
    lo = (b * 8) % 32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= lo && i < lo + 8) d[i*8 +: 8] = g[i*8 +: 8];
      else                       d[i*8 +: 8] = ~g[i*8 +: 8];
    end
    return d;
  endfunction

  // Starts just after a rising edge; returns just after the handshake edge.
  task automatic send_beat(input logic [13:0] id, input logic [255:0] d, input logic [255:0] g,
                           input logic [63:0] strb, input logic last, input logic [1:0] resp);
    logic ok;
    ok = 1'b0;
    axi_rvalid = 1'b1; axi_rid = id; axi_rdata = d; axi_rlast = last; axi_rresp = resp;
    pg_axi_rdata = g; pg_axi_rstrb = strb;
    for (int n = 0; n < 20; n++) begin
      @(negedge pg_clk);
      if (axi_rready === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL beat_handshake: got no rready, required handshake within 20 cycles"); end
    @(posedge pg_clk); #1;
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
  endtask

  task automatic do_clear();
    status_clear = 1'b1;
    @(posedge pg_clk); #1;
    status_clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pg_clk);
    checks++;
    if (axi_rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b required 0", axi_rready); end
    @(posedge pg_clk); @(posedge pg_clk); #1;
    pg_rstn = 1'b1;
    checks++;
    if ({axi_rdata_cnt_total, rd_burst_cnt, err_data_cnt, err_flags, first_err_beat, chk_halted, arcmd_info_update} !== '0) begin
      errors++; $display("FAIL reset_state: total=%0d bursts=%0d errcnt=%0d flags=%b first=%0d halted=%b upd=%b required all 0",
        axi_rdata_cnt_total, rd_burst_cnt, err_data_cnt, err_flags, first_err_beat, chk_halted, arcmd_info_update);
    end
    @(negedge pg_clk);
    checks++;
    if (axi_rready !== 1'b1) begin errors++; $display("FAIL reset_rready_after: got %b required 1", axi_rready); end
    @(posedge pg_clk); #1;
  endtask

  task automatic test_basic_burst();
    int unsigned u0;
    u0 = upd_total;
    pg_axi_arcmd_info = mk_info(3'd5, 8'd3, 14'h005);
    for (int unsigned k = 0; k < 4; k++) send_beat(14'h005, pat(k), pat(k), '1, (k == 3), 2'b00);
    checks++;
    if (axi_rdata_cnt_total !== 32'd4) begin errors++; $display("FAIL basic_total: got %0d required 4", axi_rdata_cnt_total); end
    checks++;
    if (rd_burst_cnt !== 32'd1) begin errors++; $display("FAIL basic_bursts: got %0d required 1", rd_burst_cnt); end
    checks++;
    if (err_flags !== 4'b0000) begin errors++; $display("FAIL basic_flags: got %b required 0000", err_flags); end
    checks++;
    if (upd_total - u0 !== 1) begin errors++; $display("FAIL basic_upd_pulses: got %0d required 1", upd_total - u0); end
    checks++;
    if (upd_at !== 32'd3) begin errors++; $display("FAIL basic_upd_beat: got %0d required 3", upd_at); end
  endtask

  task automatic test_data_err(input logic masked);
    logic [255:0] d;
    logic [63:0]  s;
    do_clear();
    pg_axi_arcmd_info = mk_info(3'd5, 8'd3, 14'h005);
    for (int unsigned k = 0; k < 4; k++) begin
      d = pat(k);
      s = '1;
      if (k == 2) begin
        d[7*8 +: 8] = ~d[7*8 +: 8];
        if (masked) s[7] = 1'b0;
      end
      send_beat(14'h005, d, pat(k), s, (k == 3), 2'b00);
      if (k == 2 && !masked) begin
        checks++;
        if (err_flags !== 4'b0001) begin errors++; $display("FAIL data_err_latency: got %b required 0001 after failing beat", err_flags); end
      end
    end
    checks++;
    if (err_flags !== (masked ? 4'b0000 : 4'b0001)) begin
      errors++; $display("FAIL data_flags masked=%0d: got %b required %b", masked, err_flags, masked ? 4'b0000 : 4'b0001);
    end
    checks++;
    if (err_data_cnt !== (masked ? 16'd0 : 16'd1)) begin
      errors++; $display("FAIL data_errcnt masked=%0d: got %0d required %0d", masked, err_data_cnt, masked ? 0 : 1);
    end
    if (!masked) begin
      checks++;
      if (first_err_beat !== 32'd2) begin errors++; $display("FAIL data_first_err: got %0d required 2", first_err_beat); end
    end
    checks++;
    if (rd_burst_cnt !== 32'd1) begin errors++; $display("FAIL data_bursts masked=%0d: got %0d required 1", masked, rd_burst_cnt); end
  endtask

  task automatic test_halt();
    int bad;
    do_clear();
    stop_on_err = 1'b1;
    pg_axi_arcmd_info = mk_info(3'd5, 8'd3, 14'h005);
    send_beat(14'h006, pat(0), pat(0), '1, 1'b0, 2'b00);
    checks++;
    if (err_flags !== 4'b0010) begin errors++; $display("FAIL halt_flags: got %b required 0010", err_flags); end
    checks++;
    if (chk_halted !== 1'b1) begin errors++; $display("FAIL halt_state: got %b required 1", chk_halted); end
    axi_rvalid = 1'b1;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge pg_clk);
      if (axi_rready !== 1'b0) bad++;
      @(posedge pg_clk); #1;
    end
    axi_rvalid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_rready: got ready in %0d cycles required 0", bad); end
    checks++;
    if (axi_rdata_cnt_total !== 32'd1) begin errors++; $display("FAIL halt_total: got %0d required 1", axi_rdata_cnt_total); end
    do_clear();
    stop_on_err = 1'b0;
    checks++;
    if ({axi_rdata_cnt_total, err_flags, chk_halted, first_err_beat} !== '0) begin
      errors++; $display("FAIL halt_clear: total=%0d flags=%b halted=%b first=%0d required all 0",
        axi_rdata_cnt_total, err_flags, chk_halted, first_err_beat);
    end
    @(negedge pg_clk);
    checks++;
    if (axi_rready !== 1'b1) begin errors++; $display("FAIL halt_clear_rready: got %b required 1", axi_rready); end
    @(posedge pg_clk); #1;
  endtask

  task automatic test_last_err();
    int unsigned u0;
    do_clear();
    u0 = upd_total;
    pg_axi_arcmd_info = mk_info(3'd5, 8'd3, 14'h005);
    for (int unsigned k = 0; k < 4; k++) send_beat(14'h005, pat(k), pat(k), '1, (k == 1 || k == 3), 2'b00);
    checks++;
    if (err_flags !== 4'b0100) begin errors++; $display("FAIL last_flags: got %b required 0100", err_flags); end
    checks++;
    if (first_err_beat !== 32'd1) begin errors++; $display("FAIL last_first_err: got %0d required 1", first_err_beat); end
    checks++;
    if (upd_total - u0 !== 1 || upd_at !== 32'd3) begin
      errors++; $display("FAIL last_burst_end: pulses=%0d at beat %0d required 1 at beat 3", upd_total - u0, upd_at);
    end
    checks++;
    if (rd_burst_cnt !== 32'd1) begin errors++; $display("FAIL last_bursts: got %0d required 1", rd_burst_cnt); end
  endtask

  task automatic test_resp_err();
    do_clear();
    pg_axi_arcmd_info = mk_info(3'd5, 8'd0, 14'h005);
    send_beat(14'h005, pat(0), pat(0), '1, 1'b1, 2'b10);
    checks++;
    if (err_flags !== 4'b1000) begin errors++; $display("FAIL resp_flags: got %b required 1000", err_flags); end
  endtask

  task automatic test_narrow_paced();
    int unsigned b;
    int bad;
    int unsigned u0;
    logic exp_rdy;
    logic hsnow;
    logic [255:0] d;
    do_clear();
    u0 = upd_total;
    rready_mode = 2'd1;
    pg_axi_arcmd_info = mk_info(3'd3, 8'd7, 14'h005);
    b = 0; bad = 0;
    d = mk_narrow(0);
    axi_rvalid = 1'b1; axi_rid = 14'h005; axi_rdata = d; axi_rresp = 2'b00; axi_rlast = 1'b0;
    pg_axi_rdata = pat(0); pg_axi_rstrb = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge pg_clk);
      exp_rdy = ((cyc_hi % 2) == 0);
      if (axi_rready !== exp_rdy) bad++;
      hsnow = axi_rready;
      @(posedge pg_clk); #1;
      if (hsnow) begin
        b++;
        if (b < 8) begin
          d = mk_narrow(b);
          if (b == 5) d[8*8 +: 8] = ~d[8*8 +: 8];
          axi_rdata = d; pg_axi_rdata = pat(b); axi_rlast = (b == 7);
        end else begin
          axi_rvalid = 1'b0; axi_rlast = 1'b0;
        end
      end
    end
    axi_rvalid = 1'b0;
    rready_mode = 2'd0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL paced_rready: %0d cycles off the alternating pattern, required 0", bad); end
    checks++;
    if (axi_rdata_cnt_total !== 32'd8) begin errors++; $display("FAIL paced_total: got %0d required 8 in 16 cycles", axi_rdata_cnt_total); end
    checks++;
    if (rd_burst_cnt !== 32'd1 || upd_total - u0 !== 1) begin
      errors++; $display("FAIL paced_bursts: bursts=%0d pulses=%0d required 1 and 1", rd_burst_cnt, upd_total - u0);
    end
    checks++;
    if (err_flags !== 4'b0001 || err_data_cnt !== 16'd1) begin
      errors++; $display("FAIL narrow_lanes: flags=%b errcnt=%0d required 0001 and 1", err_flags, err_data_cnt);
    end
    checks++;
    if (first_err_beat !== 32'd5) begin errors++; $display("FAIL narrow_first_err: got %0d required 5", first_err_beat); end
  endtask

  task automatic test_clear_on_last();
    int unsigned u0;
    do_clear();
    pg_axi_arcmd_info = mk_info(3'd5, 8'd3, 14'h005);
    for (int unsigned k = 0; k < 3; k++) send_beat(14'h005, pat(k), pat(k), '1, 1'b0, 2'b00);
    u0 = upd_total;
    axi_rvalid = 1'b1; axi_rdata = pat(3); pg_axi_rdata = pat(3); axi_rlast = 1'b1; status_clear = 1'b1;
    @(negedge pg_clk);
    checks++;
    if (axi_rready !== 1'b0 || arcmd_info_update !== 1'b0) begin
      errors++; $display("FAIL clear_last_hs: rready=%b upd=%b required 0 and 0", axi_rready, arcmd_info_update);
    end
    @(posedge pg_clk); #1;
    status_clear = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    checks++;
    if (axi_rdata_cnt_total !== 32'd0 || rd_burst_cnt !== 32'd0 || upd_total != u0) begin
      errors++; $display("FAIL clear_last_counters: total=%0d bursts=%0d pulses=%0d required 0 0 0",
        axi_rdata_cnt_total, rd_burst_cnt, upd_total - u0);
    end
    // A single-beat burst right after must start from beat 0.
    pg_axi_arcmd_info = mk_info(3'd5, 8'd0, 14'h005);
    send_beat(14'h005, pat(0), pat(0), '1, 1'b1, 2'b00);
    checks++;
    if (rd_burst_cnt !== 32'd1 || err_flags !== 4'b0000 || axi_rdata_cnt_total !== 32'd1) begin
      errors++; $display("FAIL clear_then_len0: bursts=%0d flags=%b total=%0d required 1 0000 1",
        rd_burst_cnt, err_flags, axi_rdata_cnt_total);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_data_err(1'b0);
    test_data_err(1'b1);
    test_halt();
    test_last_err();
    test_resp_err();
    test_narrow_paced();
    test_clear_on_last();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
